// File: rtl/hash_sched_ctrl.sv
// hash_sched_ctrl: fetches 258-byte image records, runs hash_calc on each and forwards results downstream
// Ports: start/base_addr/num_images begin a batch; busy/batch_done/timeout_err report status;
// mem_rd_* is the byte-wide image memory read port (1-cycle latency); hc_* drives and observes
// the hash engine; res_valid/res_ready/res_hash/res_index hand results on; images_done counts accepts.
module hash_sched_ctrl #(
  parameter int ADDR_W = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_images,
  output logic              busy,
  output logic              batch_done,
  output logic              timeout_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [2047:0]     hc_image_buffer,
  output logic [15:0]       hc_image_header,
  output logic              hc_buffer_valid,
  input  logic [255:0]      hc_hash_value,
  input  logic [15:0]       hc_image_index,
  input  logic              hc_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [255:0]      res_hash,
  output logic [15:0]       res_index,
  output logic [15:0]       images_done
);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [8:0] cnt_q;
  logic [WW-1:0] wd_q;
  logic [15:0] num_q;
  logic [7:0] pidx;
  logic fetch_end, wd_exp, last_img;
  // cnt_q counts FETCH cycles: 0..257 issue reads, 1..258 capture the byte read one cycle earlier
  assign fetch_end = cnt_q == 9'd258;
  assign wd_exp = wd_q == WW'(TIMEOUT_CYCLES - 1);
  assign last_img = images_done + 16'd1 == num_q;
  // pixel index of the byte captured at cnt_q (wraps correctly for cnt_q = 258)
  assign pidx = cnt_q[7:0] - 8'd3;
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start && num_images != 16'd0 ? FETCH : IDLE;
      FETCH:   state_d = fetch_end ? ISSUE : FETCH;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = hc_done ? OUTPUT : wd_exp ? IDLE : WAIT;
      OUTPUT:  state_d = !res_ready ? OUTPUT : last_img ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    mem_rd_en = state_q == FETCH && !fetch_end;
    hc_buffer_valid = state_q == ISSUE;
    res_valid = state_q == OUTPUT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_done <= 1'b0;
      timeout_err <= 1'b0;
      mem_rd_addr <= '0;
      hc_image_header <= '0;
      hc_image_buffer <= '0;
      res_hash <= '0;
      res_index <= '0;
      images_done <= '0;
      num_q <= '0;
      cnt_q <= '0;
      wd_q <= '0;
    end else begin
      cnt_q <= state_q == FETCH ? cnt_q + 9'd1 : '0;
      wd_q <= state_q == WAIT ? wd_q + WW'(1) : '0;
      batch_done <= (state_q == IDLE && start && num_images == 16'd0) ||
                    (state_q == WAIT && !hc_done && wd_exp) ||
                    (state_q == OUTPUT && res_ready && last_img);
      if (state_q == IDLE && start) begin
        mem_rd_addr <= base_addr;
        num_q <= num_images;
        images_done <= '0;
        timeout_err <= 1'b0;
      end
      if (state_q == WAIT && !hc_done && wd_exp)
        timeout_err <= 1'b1;
      // after a record's 258 reads the address already points at the next record
      if (mem_rd_en)
        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
      if (state_q == FETCH && cnt_q == 9'd1)
        hc_image_header[15:8] <= mem_rd_data;
      if (state_q == FETCH && cnt_q == 9'd2)
        hc_image_header[7:0] <= mem_rd_data;
      if (state_q == FETCH && cnt_q >= 9'd3)
        hc_image_buffer[{pidx, 3'b000} +: 8] <= mem_rd_data;
      if (state_q == WAIT && hc_done) begin
        res_hash <= hc_hash_value;
        res_index <= hc_image_index;
      end
      if (state_q == OUTPUT && res_ready)
        images_done <= images_done + 16'd1;
    end
  end
endmodule

// File: tb/tb_hash_sched_ctrl.sv
// tb_hash_sched_ctrl: directed and randomized batches checked against a record-level model
module tb_hash_sched_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [15:0] num_images = '0;
  logic busy, batch_done, timeout_err, mem_rd_en, hc_buffer_valid, res_valid;
  logic [23:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [2047:0] hc_image_buffer;
  logic [15:0] hc_image_header, hc_image_index, res_index, images_done;
  logic [255:0] hc_hash_value, res_hash;
  logic hc_done = 1'b0;
  logic res_ready = 1'b1;
  hash_sched_ctrl #(.ADDR_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_images(num_images),
    .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .hc_image_buffer(hc_image_buffer), .hc_image_header(hc_image_header),
    .hc_buffer_valid(hc_buffer_valid), .hc_hash_value(hc_hash_value),
    .hc_image_index(hc_image_index), .hc_done(hc_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash),
    .res_index(res_index), .images_done(images_done));
  int n_vec = 0, n_err = 0, cyc = 0, t0 = 0, edelay = 4, ecnt = 0;
  int unsigned mmul = 1, madd = 0;
  bit stall_en = 1'b0, rdy_rand = 1'b0;
  logic [23:0] rd_a[$];
  int rd_c[$], hv_c[$], bd_c[$];
  logic [15:0] hd_q[$], ai_q[$], ei_q[$];
  logic [2047:0] bf_q[$];
  logic [255:0] ah_q[$], eh_q[$];
  int bd_n = 0, vtot = 0, stall_n = 0, hold_bad = 0, rd_out = 0, vcyc = 0;
  logic prev_v = 1'b0, prev_acc = 1'b0;
  logic [255:0] prev_h = '0;
  logic [15:0] prev_i = '0;
  int rd0, hv0, bc0, b0, eh0, ac0, st0, vt0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory contents are an affine function of the byte address
  function automatic logic [7:0] mb(input logic [23:0] a);
    return 8'(32'(a) * mmul + madd);
  endfunction
  function automatic logic [2047:0] exp_buf(input logic [23:0] rec);
    logic [2047:0] b;
    for (int i = 0; i < 256; i++) b[8*i +: 8] = mb(24'(rec + 24'd2 + 24'(i)));
    return b;
  endfunction
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mb(mem_rd_addr) : 8'($urandom);
  // engine: done pulse edelay+1 cycles into WAIT (edelay=0 never finishes); junk hash otherwise
  always @(posedge clk) begin : eng
    logic [255:0] h;
    logic [15:0] ix;
    for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom;
    ix = 16'($urandom);
    hc_hash_value <= h;
    hc_image_index <= ix;
    hc_done <= 1'b0;
    if (hc_buffer_valid) ecnt <= edelay;
    else if (ecnt != 0) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) begin
        hc_done <= 1'b1;
        eh_q.push_back(h);
        ei_q.push_back(ix);
      end
    end
  end
  always @(posedge clk) begin
    #2;
    res_ready = (stall_en && res_valid && vcyc < 20) ? 1'b0 : rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end
  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_a.push_back(mem_rd_addr);
      rd_c.push_back(cyc);
      if (res_valid) rd_out++;
    end
    if (hc_buffer_valid) begin
      hv_c.push_back(cyc);
      hd_q.push_back(hc_image_header);
      bf_q.push_back(hc_image_buffer);
    end
    if (batch_done) begin
      bd_n++;
      bd_c.push_back(cyc);
    end
    if (res_valid && res_ready) begin
      ah_q.push_back(res_hash);
      ai_q.push_back(res_index);
    end
    if (res_valid) vtot++;
    if (res_valid && !res_ready) stall_n++;
    if (res_valid && prev_v && !prev_acc && (res_hash !== prev_h || res_index !== prev_i)) hold_bad++;
    prev_v = res_valid;
    prev_acc = res_valid && res_ready;
    prev_h = res_hash;
    prev_i = res_index;
    vcyc = res_valid ? vcyc + 1 : 0;
  end
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic mark;
    rd0 = rd_a.size(); hv0 = hv_c.size(); bc0 = bd_c.size(); b0 = bd_n;
    eh0 = eh_q.size(); ac0 = ah_q.size(); st0 = stall_n; vt0 = vtot;
  endtask
  task automatic start_batch(input logic [23:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_images = n;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask
  task automatic wait_bd(input int budget);
    int n = 0;
    while (bd_n == b0 && n < budget) begin
      tick;
      n++;
    end
    check("bd_seen", bd_n != b0, 1);
  endtask
  task automatic check_rst(input string t);
    check({t, "_busy"}, busy, 0);
    check({t, "_bd"}, batch_done, 0);
    check({t, "_tmo"}, timeout_err, 0);
    check({t, "_rden"}, mem_rd_en, 0);
    check({t, "_hcv"}, hc_buffer_valid, 0);
    check({t, "_rv"}, res_valid, 0);
    check({t, "_addr"}, mem_rd_addr, 0);
    check({t, "_hdr"}, hc_image_header, 0);
    check({t, "_hash"}, res_hash, 0);
    check({t, "_idx"}, res_index, 0);
    check({t, "_done"}, images_done, 0);
    for (int c = 0; c < 8; c++) check({t, "_buf"}, hc_image_buffer[256*c +: 256], 0);
  endtask
  task automatic run_batch(input logic [23:0] base, input int num, input bit poke);
    int bad = 0;
    mark;
    start_batch(base, 16'(num));
    if (poke) begin
      tick; tick;
      start = 1'b1; base_addr = 24'h00abcd; num_images = 16'd7;
      tick; tick;
      start = 1'b0;
    end
    wait_bd(400 * num + 200);
    repeat (3) tick;
    check("bd_cnt", bd_n - b0, 1);
    check("img_done", images_done, num);
    check("tmo_clear", timeout_err, 0);
    check("idle", busy, 0);
    check("rd_cnt", rd_a.size() - rd0, 258 * num);
    for (int i = 0; i < 258 * num && rd0 + i < rd_a.size(); i++)
      if (rd_a[rd0 + i] !== 24'(base + 24'(i))) bad++;
    check("rd_addr", bad, 0);
    for (int r = 0; r < num; r++) begin
      logic [23:0] rec;
      logic [2047:0] eb, ob;
      rec = 24'(base + 24'(258 * r));
      eb = exp_buf(rec);
      ob = bf_q[hv0 + r];
      check("hdr", hd_q[hv0 + r], {mb(rec), mb(24'(rec + 24'd1))});
      for (int c = 0; c < 8; c++) check("pix", ob[256*c +: 256], eb[256*c +: 256]);
    end
    check("res_cnt", ah_q.size() - ac0, num);
    for (int k = 0; k < num; k++) begin
      check("res_hash", ah_q[ac0 + k], eh_q[eh0 + k]);
      check("res_idx", ai_q[ac0 + k], ei_q[eh0 + k]);
    end
  endtask
  // base 0x100, identity memory, done 5 cycles after valid, res_ready high
  task automatic timing1;
    logic [2047:0] ob;
    ob = bf_q[hv0];
    check("t_rd_first", rd_c[rd0] - t0 + 1, 1);
    check("t_rd_last", rd_c[rd0 + 257] - t0 + 1, 258);
    check("t_hcv", hv_c[hv0] - t0 + 1, 260);
    check("t_bd", bd_c[bc0] - t0 + 1, 267);
    check("t_hdr", hd_q[hv0], 16'h0001);
    check("t_pix0", ob[7:0], 8'h02);
    check("t_pix255", ob[2047:2040], 8'h01);
    check("t_rv_cycles", vtot - vt0, 1);
  endtask
  task automatic tmo_batch;
    mark;
    start_batch(24'h000000, 16'd1);
    wait_bd(400);
    tick;
    check("to_bd_rel", bd_c[bc0] - t0 + 1, 277);
    check("to_err", timeout_err, 1);
    check("to_idle", busy, 0);
    check("to_imgs", images_done, 0);
    check("to_no_res", vtot - vt0, 0);
    check("to_bd_cnt", bd_n - b0, 1);
  endtask
  initial begin
    repeat (3) tick;
    check_rst("rst");
    reset = 1'b0;
    tick;
    mark;
    start_batch(24'h123456, 16'd0);
    check("z_bd_now", batch_done, 1);
    check("z_busy", busy, 0);
    tick; tick;
    check("z_bd_cnt", bd_n - b0, 1);
    check("z_bd_rel", bd_c[bc0] - t0 + 1, 1);
    check("z_reads", rd_a.size() - rd0, 0);
    check("z_bd_low", batch_done, 0);
    run_batch(24'h000100, 1, 1'b0);
    timing1;
    run_batch(24'h000000, 3, 1'b1);
    check("m_rec2", rd_a[rd0 + 258], 258);
    check("m_rec3", rd_a[rd0 + 516], 516);
    stall_en = 1'b1;
    run_batch(24'h00abc0, 1, 1'b0);
    stall_en = 1'b0;
    check("st_cycles", stall_n - st0, 20);
    check("st_hold", hold_bad, 0);
    check("st_no_rd", rd_out, 0);
    edelay = 0;
    tmo_batch;
    edelay = 16;
    tmo_batch;
    repeat (5) tick;
    check("to_sticky", timeout_err, 1);
    mark;
    start_batch(24'h000000, 16'd0);
    check("to_clr", timeout_err, 0);
    tick; tick;
    edelay = 15;
    run_batch(24'h000200, 1, 1'b0);
    edelay = 4;
    mark;
    start_batch(24'h000100, 16'd1);
    while (cyc - t0 + 1 < 100) tick;
    check("r_in_fetch", mem_rd_en, 1);
    reset = 1'b1;
    tick;
    check_rst("rmid");
    check("r_no_bd", bd_n - b0, 0);
    reset = 1'b0;
    tick;
    run_batch(24'h000100, 1, 1'b0);
    timing1;
    rdy_rand = 1'b1;
    for (int it = 0; it < 4; it++) begin
      mmul = $urandom | 1;
      madd = $urandom;
      edelay = $urandom_range(1, 14);
      run_batch(it == 0 ? 24'hFFFF00 : 24'($urandom), $urandom_range(1, 3), 1'b0);
    end
    check("hold_all", hold_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hash_sched_ctrl.md
Name: hash_sched_ctrl

Overview:
- Sequences the hash_calc engine over a batch of images held in byte-wide image memory.
- Per image: fetches the 258-byte record (2 header bytes, 256 pixel bytes) into a local buffer, pulses the engine, waits for completion, then forwards hash and index downstream over a valid/ready handshake.
- Sits between the image memory read port and the reordering/sort stage.
- A watchdog aborts the batch if the engine hangs.

Parameters:
- ADDR_W, 24, image memory byte-address width.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before abort; must be ≥ 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  batch start; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first record; latched on accepted start.
- num_images  in  16  record count; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse when the batch ends (normal or abort).
- timeout_err  out  1  sticky; set on watchdog abort, cleared on the next accepted start.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory byte address.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- hc_image_buffer  out  256x8  pixel buffer to the engine; element i = pixel i.
- hc_image_header  out  16  record header to the engine.
- hc_buffer_valid  out  1  one-cycle engine start pulse.
- hc_hash_value  in  256  engine result.
- hc_image_index  in  16  engine index result.
- hc_done  in  1  engine completion; level or pulse, first high cycle in WAIT counts.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accept.
- res_hash  out  256  captured hash.
- res_index  out  16  captured index.
- images_done  out  16  count of results accepted in the current batch.

Behaviour:
- Reset values (sync reset, applies mid-operation, aborts any batch with no batch_done pulse):
  - state = IDLE.
  - busy, batch_done, timeout_err, mem_rd_en, hc_buffer_valid, res_valid = 0.
  - mem_rd_addr, hc_image_header, res_hash, res_index, images_done = 0.
  - hc_image_buffer = all zeros.
- States: IDLE, FETCH, ISSUE, WAIT, OUTPUT.
- IDLE:
  - start=1 latches base_addr and num_images, clears images_done and timeout_err.
  - If num_images=0: pulse batch_done next cycle and stay in IDLE; no memory reads.
  - Otherwise go to FETCH.
  - start while busy is ignored.
- FETCH:
  - mem_rd_en=1 for exactly 258 consecutive cycles, addresses rec_addr .. rec_addr+257. rec_addr is base_addr for the first record.
  - Byte 0 goes to header[15:8], byte 1 to header[7:0], bytes 2..257 to pixels 0..255.
  - FETCH exits the cycle after the last data byte is captured.
  - Timing: start accepted at edge T0, reads in cycles T1..T258, data in T2..T259, ISSUE in T260.
  - Address wraps modulo 2^ADDR_W.
- ISSUE:
  - hc_buffer_valid=1 for one cycle, then go to WAIT.
  - hc_image_buffer and hc_image_header stay stable from ISSUE until the next FETCH begins.
- WAIT:
  - Watchdog counter starts at 0 on entry and increments each cycle.
  - hc_done=1 captures hc_hash_value into res_hash and hc_image_index into res_index, then goes to OUTPUT. hc_done takes priority if it coincides with the timeout.
  - Counter reaching TIMEOUT_CYCLES-1 with no hc_done sets timeout_err, pulses batch_done, and returns to IDLE.
  - hc_done outside WAIT is ignored.
- OUTPUT:
  - res_valid=1; res_hash and res_index held stable until accepted.
  - res_valid & res_ready increments images_done and drops res_valid next cycle.
  - If images_done+1 = num_images: pulse batch_done, go to IDLE.
  - Otherwise go to FETCH with rec_addr += 258.
  - res_ready while res_valid=0 has no effect.
- Arithmetic:
  - images_done is 16-bit; num_images = 65535 completes without wrap.
  - rec_addr advances by 258 per record, modulo 2^ADDR_W.

Test Plan:
- Reset then start with num_images=0 → batch_done pulses the cycle after start; mem_rd_en never asserts; busy stays 0.
- base_addr=0x000100, num_images=1, memory byte k = k[7:0], engine model returns done 5 cycles after valid, res_ready=1 → mem_rd_en in T1..T258, hc_buffer_valid at T260, hc_image_header=0x0001, pixel[0]=0x02, pixel[255]=0x01, res_valid one cycle, batch_done pulse, images_done=1.
- num_images=3, base_addr=0 → second record reads start at address 258, third at 516; three results accepted in order; batch_done pulses once.
- res_ready held low 20 cycles in OUTPUT → res_valid high and res_hash stable all 20 cycles; no new memory read until the handshake completes.
- Engine never asserts hc_done, TIMEOUT_CYCLES=16 → 16 cycles in WAIT, timeout_err=1, batch_done pulse, IDLE; next start clears timeout_err.
- reset asserted mid-FETCH (cycle T100) → next cycle all outputs at reset values, IDLE, no batch_done; a fresh start behaves as in scenario 2.
